eth_tx_sched: RTL and testbench



---
 rtl/eth_tx_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_eth_tx_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: ARP resolve/answer/refresh plus round-robin UDP arbitration onto one TX port.
// Define ETH_TX_SCHED_STATS_EN to add 16-bit ARP/UDP/timeout event counters.
module eth_tx_sched #(
  parameter int N_CH        = 2,
  parameter int ARP_TIMEOUT = 125000000,
  parameter int ARP_RETRIES = 3,
  parameter int ARP_REFRESH = 1000000000,
  parameter int IFG_CYCLES  = 12
) (
  input  logic            eth_tx_clk,
  input  logic            rst_n,
  input  logic            i_arp_req_tgl,
  input  logic            i_arp_resp_tgl,
  input  logic [47:0]     i_rx_mac,
  output logic            o_arp_start,
  output logic [1:0]      o_arp_oper,
  input  logic            i_arp_ready,
  input  logic [N_CH-1:0] i_ch_req,
  output logic [N_CH-1:0] o_ch_grant,
  output logic            o_udp_start,
  input  logic            i_udp_ready,
  output logic            o_tx_sel,
  output logic [47:0]     o_peer_mac,
  output logic            o_peer_valid,
  output logic            o_arp_fail
`ifdef ETH_TX_SCHED_STATS_EN
  ,
  output logic [15:0]     o_arp_tx_cnt,
  output logic [15:0]     o_udp_tx_cnt,
  output logic [15:0]     o_arp_timeout_cnt
`endif
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [31:0] TMO_LAST = 32'(ARP_TIMEOUT - 1);
  localparam logic [31:0] IFG_LAST =
    32'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [31:0] REF_MAX  = 32'(ARP_REFRESH);
  localparam logic [7:0]  RTY_LAST = 8'(ARP_RETRIES - 1);

  typedef enum logic [3:0] {
    S_INIT, S_ARP_START, S_ARP_SEND, S_ARP_WAIT, S_IDLE,
    S_RSP_START, S_RSP_SEND, S_UDP_START, S_UDP_SEND, S_GAP
  } state_t;

  state_t state, state_nxt;

  logic [2:0]    req_s, rsp_s;
  logic          req_evt, rsp_evt;
  logic          req_pend;
  logic [31:0]   tmr;
  logic [31:0]   ref_cnt;
  logic [7:0]    rty_cnt;
  logic [PW-1:0] rr_ptr, pick_idx;
  logic [PW:0]   idx, ptr_nxt;
  logic          found;
  logic          tmo_hit, ref_hit, ifg_hit;
  logic          rsp_go, udp_go, gap_in, arp_done, udp_done;

  // Third stage gives the edge detector its previous value
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_s <= '0;
      rsp_s <= '0;
    end else begin
      req_s <= {req_s[1:0], i_arp_req_tgl};
      rsp_s <= {rsp_s[1:0], i_arp_resp_tgl};
    end
  end

  assign req_evt = req_s[2] ^ req_s[1];
  assign rsp_evt = rsp_s[2] ^ rsp_s[1];

  assign tmo_hit = (state == S_ARP_WAIT) && (tmr == TMO_LAST);
  assign ifg_hit = (state == S_GAP) && (tmr >= IFG_LAST);
  assign ref_hit = (ref_cnt == REF_MAX);

  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    idx      = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N_CH))
        idx = idx - (PW+1)'(N_CH);
      if (!found && i_ch_req[idx[PW-1:0]]) begin
        found    = 1'b1;
        pick_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_nxt = {1'b0, pick_idx} + (PW+1)'(1);
    if (ptr_nxt >= (PW+1)'(N_CH))
      ptr_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:      if (i_arp_ready) state_nxt = S_ARP_START;
      S_ARP_START: if (!i_arp_ready) state_nxt = S_ARP_SEND;
      S_ARP_SEND:  if (i_arp_ready) state_nxt = S_ARP_WAIT;
      S_ARP_WAIT: begin
        if (rsp_evt)
          state_nxt = S_IDLE;
        else if (tmo_hit)
          state_nxt = (rty_cnt >= RTY_LAST) ? S_IDLE : S_ARP_START;
      end
      S_IDLE: begin
        if (req_pend && i_arp_ready)
          state_nxt = S_RSP_START;
        else if (ref_hit && i_arp_ready)
          state_nxt = S_ARP_START;
        else if (found && o_peer_valid && i_udp_ready)
          state_nxt = S_UDP_START;
      end
      S_RSP_START: if (!i_arp_ready) state_nxt = S_RSP_SEND;
      S_RSP_SEND:  if (i_arp_ready) state_nxt = S_IDLE;
      S_UDP_START: if (!i_udp_ready) state_nxt = S_UDP_SEND;
      S_UDP_SEND:  if (i_udp_ready) state_nxt = S_GAP;
      S_GAP:       if (ifg_hit) state_nxt = S_IDLE;
      default:     state_nxt = S_INIT;
    endcase
  end

  assign rsp_go   = (state == S_IDLE) && (state_nxt == S_RSP_START);
  assign udp_go   = (state == S_IDLE) && (state_nxt == S_UDP_START);
  assign gap_in   = (state == S_UDP_SEND) && i_udp_ready;
  assign udp_done = gap_in;
  assign arp_done = ((state == S_ARP_SEND) || (state == S_RSP_SEND))
                    && i_arp_ready;

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Single timer serves both ARP_WAIT timeout and inter-frame gap
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n)
      tmr <= '0;
    else if (state_nxt != state)
      tmr <= '0;
    else if ((state == S_ARP_WAIT) || (state == S_GAP))
      tmr <= tmr + 32'd1;
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n)
      ref_cnt <= '0;
    else if (arp_done)
      ref_cnt <= '0;
    else if (!ref_hit)
      ref_cnt <= ref_cnt + 32'd1;
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n)
      req_pend <= 1'b0;
    else
      req_pend <= req_evt | (req_pend & ~rsp_go);
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_peer_mac   <= '0;
      o_peer_valid <= 1'b0;
      o_arp_fail   <= 1'b0;
      rty_cnt      <= '0;
    end else begin
      if (rsp_evt) begin
        o_peer_mac   <= i_rx_mac;
        o_peer_valid <= 1'b1;
      end
      if ((state == S_ARP_WAIT) && rsp_evt) begin
        rty_cnt    <= '0;
        o_arp_fail <= 1'b0;
      end else if (tmo_hit) begin
        if (rty_cnt >= RTY_LAST) begin
          rty_cnt    <= '0;
          o_arp_fail <= 1'b1;
        end else begin
          rty_cnt <= rty_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ch_grant <= '0;
      rr_ptr     <= '0;
    end else if (udp_go) begin
      o_ch_grant <= N_CH'(1) << pick_idx;
      rr_ptr     <= ptr_nxt[PW-1:0];
    end else if (gap_in) begin
      o_ch_grant <= '0;
    end
  end

  assign o_arp_start = (state == S_ARP_START) || (state == S_RSP_START);
  assign o_udp_start = (state == S_UDP_START);
  assign o_tx_sel    = (state == S_UDP_START) || (state == S_UDP_SEND);

  always_comb begin
    o_arp_oper = 2'd0;
    unique case (1'b1)
      (state == S_ARP_START),
      (state == S_ARP_SEND): o_arp_oper = 2'd1;
      (state == S_RSP_START),
      (state == S_RSP_SEND): o_arp_oper = 2'd2;
      default:               o_arp_oper = 2'd0;
    endcase
  end

`ifdef ETH_TX_SCHED_STATS_EN
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_arp_tx_cnt      <= '0;
      o_udp_tx_cnt      <= '0;
      o_arp_timeout_cnt <= '0;
    end else begin
      if (arp_done) o_arp_tx_cnt <= o_arp_tx_cnt + 16'd1;
      if (udp_done) o_udp_tx_cnt <= o_udp_tx_cnt + 16'd1;
      if (tmo_hit && !rsp_evt)
        o_arp_timeout_cnt <= o_arp_timeout_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: scoreboard bench for eth_tx_sched with mock ARP/UDP senders.
// Expected ARP opers and channel grants are queued as stimulus is driven.
module tb_eth_tx_sched;

  localparam int N_CH    = 2;
  localparam int TMO     = 100;
  localparam int RETRIES = 3;
  localparam int REFRESH = 1500;
  localparam int IFG     = 12;

  logic            eth_tx_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_arp_req_tgl = 1'b0;
  logic            i_arp_resp_tgl = 1'b0;
  logic [47:0]     i_rx_mac = '0;
  logic            o_arp_start;
  logic [1:0]      o_arp_oper;
  logic            i_arp_ready = 1'b1;
  logic [N_CH-1:0] i_ch_req = '0;
  logic [N_CH-1:0] o_ch_grant;
  logic            o_udp_start;
  logic            i_udp_ready = 1'b1;
  logic            o_tx_sel;
  logic [47:0]     o_peer_mac;
  logic            o_peer_valid;
  logic            o_arp_fail;

  eth_tx_sched #(
    .N_CH(N_CH), .ARP_TIMEOUT(TMO), .ARP_RETRIES(RETRIES),
    .ARP_REFRESH(REFRESH), .IFG_CYCLES(IFG)
  ) dut (
    .eth_tx_clk(eth_tx_clk), .rst_n(rst_n),
    .i_arp_req_tgl(i_arp_req_tgl), .i_arp_resp_tgl(i_arp_resp_tgl),
    .i_rx_mac(i_rx_mac), .o_arp_start(o_arp_start),
    .o_arp_oper(o_arp_oper), .i_arp_ready(i_arp_ready),
    .i_ch_req(i_ch_req), .o_ch_grant(o_ch_grant),
    .o_udp_start(o_udp_start), .i_udp_ready(i_udp_ready),
    .o_tx_sel(o_tx_sel), .o_peer_mac(o_peer_mac),
    .o_peer_valid(o_peer_valid), .o_arp_fail(o_arp_fail)
  );

  always #5 eth_tx_clk = ~eth_tx_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge eth_tx_clk) cyc <= cyc + 1;

  logic [1:0]      exp_oper_q[$];
  logic [N_CH-1:0] exp_gnt_q[$];
  int arp_starts = 0;
  int rsp_starts = 0;
  int udp_starts = 0;
  int arp_end_cyc = 0;
  int tx_fall = -1;
  logic pa = 1'b0, pu = 1'b0, pt = 1'b0;
  logic [1:0] po = 2'd0;

  task automatic check(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: compares each new start against the queues
  initial begin
    forever begin
      @(negedge eth_tx_clk);
      if (!rst_n) begin
        pa = 1'b0; pu = 1'b0; pt = 1'b0; po = 2'd0; tx_fall = -1;
      end else begin
        if (o_arp_start && !pa) begin
          arp_starts++;
          if (o_arp_oper == 2'd2) rsp_starts++;
          if (exp_oper_q.size() == 0)
            check("arp_unexpected", 48'(o_arp_oper), 48'd0);
          else
            check("arp_oper", 48'(o_arp_oper), 48'(exp_oper_q.pop_front()));
        end
        if (o_udp_start && !pu) begin
          udp_starts++;
          if (exp_gnt_q.size() == 0)
            check("udp_unexpected", 48'(o_ch_grant), 48'd0);
          else
            check("grant", 48'(o_ch_grant), 48'(exp_gnt_q.pop_front()));
          if (tx_fall >= 0)
            check("ifg_gap", 48'((cyc - tx_fall) >= IFG), 48'd1);
        end
        if (!o_tx_sel && pt) tx_fall = cyc;
        if (po != 2'd0 && o_arp_oper == 2'd0) arp_end_cyc = cyc;
        pa = o_arp_start; pu = o_udp_start; pt = o_tx_sel;
        po = o_arp_oper;
      end
    end
  end

  // Mock ARP sender: busy for 6 cycles after each start
  initial begin
    forever begin
      @(negedge eth_tx_clk);
      if (o_arp_start && i_arp_ready) begin
        i_arp_ready = 1'b0;
        repeat (6) @(negedge eth_tx_clk);
        i_arp_ready = 1'b1;
      end
    end
  end

  // Mock UDP sender: 20-cycle frames
  initial begin
    forever begin
      @(negedge eth_tx_clk);
      if (o_udp_start && i_udp_ready) begin
        i_udp_ready = 1'b0;
        repeat (20) @(negedge eth_tx_clk);
        i_udp_ready = 1'b1;
      end
    end
  end

  task automatic wait_arp(input int n, input int lim, input string tag);
    int k = 0;
    while (arp_starts < n && k < lim) begin
      @(negedge eth_tx_clk);
      k++;
    end
    check(tag, 48'(arp_starts >= n), 48'd1);
  endtask

  task automatic wait_udp(input int n, input int lim, input string tag);
    int k = 0;
    while (udp_starts < n && k < lim) begin
      @(negedge eth_tx_clk);
      k++;
    end
    check(tag, 48'(udp_starts >= n), 48'd1);
  endtask

  task automatic wait_arp_wait(input string tag);
    int k = 0;
    while (o_arp_oper != 2'd0 && k < 50) begin
      @(negedge eth_tx_clk);
      k++;
    end
    check(tag, 48'(o_arp_oper), 48'd0);
  endtask

  task automatic send_resp(input logic [47:0] mac);
    i_rx_mac = mac;
    i_arp_resp_tgl = ~i_arp_resp_tgl;
    repeat (6) @(negedge eth_tx_clk);
  endtask

  initial begin
    int k;
    int t1;
    int n0;
    repeat (3) @(negedge eth_tx_clk);
    check("rst_arp_start", 48'(o_arp_start), 48'd0);
    check("rst_oper", 48'(o_arp_oper), 48'd0);
    check("rst_udp_start", 48'(o_udp_start), 48'd0);
    check("rst_tx_sel", 48'(o_tx_sel), 48'd0);
    check("rst_grant", 48'(o_ch_grant), 48'd0);
    check("rst_peer_valid", 48'(o_peer_valid), 48'd0);
    check("rst_peer_mac", o_peer_mac, 48'd0);
    check("rst_fail", 48'(o_arp_fail), 48'd0);

    // No response: bounded retries then sticky failure
    repeat (RETRIES) exp_oper_q.push_back(2'd1);
    rst_n = 1'b1;
    k = 0;
    while (!o_arp_fail && k < 600) begin
      @(negedge eth_tx_clk);
      k++;
    end
    check("arp_fail_set", 48'(o_arp_fail), 48'd1);
    check("req_count", 48'(arp_starts), 48'(RETRIES));
    check("fail_peer_valid", 48'(o_peer_valid), 48'd0);

    // Refresh retries after failure; answer 20 cycles into ARP_WAIT
    exp_oper_q.push_back(2'd1);
    wait_arp(RETRIES + 1, 2000, "refresh_after_fail");
    wait_arp_wait("enter_wait_1");
    repeat (20) @(negedge eth_tx_clk);
    send_resp(48'h0C54A5312485);
    check("peer_valid", 48'(o_peer_valid), 48'd1);
    check("peer_mac", o_peer_mac, 48'h0C54A5312485);
    check("fail_cleared", 48'(o_arp_fail), 48'd0);
    repeat (150) @(negedge eth_tx_clk);
    check("no_retry_after_resp", 48'(arp_starts), 48'(RETRIES + 1));

    // Round-robin on two continuous requesters
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    i_ch_req = 2'b11;
    wait_udp(4, 400, "rr_frames");
    i_ch_req = 2'b00;
    repeat (40) @(negedge eth_tx_clk);
    check("rr_count", 48'(udp_starts), 48'd4);

    // ARP requests during a frame collapse into one deferred response
    exp_gnt_q.push_back(2'b01);
    i_ch_req = 2'b01;
    wait_udp(5, 100, "frame_5");
    i_ch_req = 2'b00;
    exp_oper_q.push_back(2'd2);
    repeat (3) @(negedge eth_tx_clk);
    i_arp_req_tgl = ~i_arp_req_tgl;
    repeat (5) @(negedge eth_tx_clk);
    i_arp_req_tgl = ~i_arp_req_tgl;
    repeat (3) @(negedge eth_tx_clk);
    check("grant_held", 48'(o_ch_grant), 48'(2'b01));
    check("tx_sel_udp", 48'(o_tx_sel), 48'd1);
    check("no_rsp_mid_frame", 48'(rsp_starts), 48'd0);
    wait_arp(RETRIES + 2, 100, "rsp_after_frame");
    repeat (60) @(negedge eth_tx_clk);
    check("rsp_count", 48'(rsp_starts), 48'd1);
    check("arp_total", 48'(arp_starts), 48'(RETRIES + 2));

    // Saturated refresh preempts a waiting channel
    exp_oper_q.push_back(2'd1);
    i_ch_req = 2'b10;
    k = 0;
    while (arp_starts < RETRIES + 3 && k < 2500) begin
      if (exp_gnt_q.size() == 0) exp_gnt_q.push_back(2'b10);
      @(negedge eth_tx_clk);
      k++;
    end
    i_ch_req = 2'b00;
    t1 = cyc;
    check("refresh_seen", 48'(arp_starts >= RETRIES + 3), 48'd1);
    check("refresh_interval",
          48'((t1 - arp_end_cyc >= REFRESH) &&
              (t1 - arp_end_cyc <= REFRESH + 40)), 48'd1);
    check("refresh_tx_sel", 48'(o_tx_sel), 48'd0);
    check("refresh_grant", 48'(o_ch_grant), 48'd0);
    wait_arp_wait("enter_wait_2");
    send_resp(48'hA1B2C3D4E5F6);
    check("refresh_mac", o_peer_mac, 48'hA1B2C3D4E5F6);
    repeat (40) @(negedge eth_tx_clk);
    exp_gnt_q.delete();

    // Gratuitous response while idle
    send_resp(48'h020000000001);
    check("gratuitous_mac", o_peer_mac, 48'h020000000001);
    check("gratuitous_valid", 48'(o_peer_valid), 48'd1);

    // Reset in the middle of a frame
    exp_gnt_q.push_back(2'b01);
    i_ch_req = 2'b01;
    wait_udp(udp_starts + 1, 100, "frame_before_rst");
    repeat (5) @(negedge eth_tx_clk);
    check("pre_rst_tx_sel", 48'(o_tx_sel), 48'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_sel", 48'(o_tx_sel), 48'd0);
    check("mid_rst_grant", 48'(o_ch_grant), 48'd0);
    check("mid_rst_udp_start", 48'(o_udp_start), 48'd0);
    check("mid_rst_peer_valid", 48'(o_peer_valid), 48'd0);
    check("mid_rst_peer_mac", o_peer_mac, 48'd0);
    check("mid_rst_oper", 48'(o_arp_oper), 48'd0);
    i_ch_req = 2'b00;
    n0 = arp_starts;
    exp_oper_q.push_back(2'd1);
    repeat (4) @(negedge eth_tx_clk);
    rst_n = 1'b1;
    wait_arp(n0 + 1, 100, "arp_after_rst");
    check("post_rst_oper", 48'(o_arp_oper), 48'd1);
    check("post_rst_peer_valid", 48'(o_peer_valid), 48'd0);
    repeat (5) @(negedge eth_tx_clk);
    check("oper_queue_empty", 48'(exp_oper_q.size()), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
